// File: rtl/swg_window_deduplicator.sv
//------------------------------------------------------------------------------
// swg_window_deduplicator
//
// Receiving-end inverse of the sliding-window generator. It consumes the SWG
// window stream (kernel rows, then kernel columns, then channel folds, with
// windows in output-raster order). Each input-feature-map element is re-emitted
// exactly once, in first-appearance order. Beats that repeat an element already
// covered by an earlier window are consumed and dropped.
//
// Optional feature: define SWG_DEDUP_TLAST_EN to add out_V_V_TLAST, which marks
// the last kept beat of each frame.
//
// Ports:
//   ap_clk          in   clock, rising edge
//   ap_rst          in   synchronous active-high reset
//   in0_V_V_TVALID  in   window-stream beat valid
//   in0_V_V_TREADY  out  window-stream beat accepted
//   in0_V_V_TDATA   in   window-stream beat (BIT_WIDTH*SIMD)
//   out_V_V_TVALID  out  deduplicated beat valid
//   out_V_V_TREADY  in   sink ready
//   out_V_V_TDATA   out  deduplicated beat (BIT_WIDTH*SIMD)
//   out_V_V_TLAST   out  last beat of frame (only with SWG_DEDUP_TLAST_EN)
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module swg_window_deduplicator #(
    parameter int unsigned BIT_WIDTH = 8,
    parameter int unsigned SIMD      = 1,
    parameter int unsigned CHANNELS  = 1,
    parameter int unsigned IFM_DIM   = 4,
    parameter int unsigned K         = 2,
    parameter int unsigned STRIDE    = 1
) (
    input  logic                      ap_clk,
    input  logic                      ap_rst,
    input  logic                      in0_V_V_TVALID,
    output logic                      in0_V_V_TREADY,
    input  logic [BIT_WIDTH*SIMD-1:0] in0_V_V_TDATA,
    output logic                      out_V_V_TVALID,
    input  logic                      out_V_V_TREADY,
    output logic [BIT_WIDTH*SIMD-1:0] out_V_V_TDATA
`ifdef SWG_DEDUP_TLAST_EN
    ,
    output logic                      out_V_V_TLAST
`endif
);

    localparam int unsigned CF      = CHANNELS / SIMD;
    localparam int unsigned OFM_DIM = (IFM_DIM - K) / STRIDE + 1;

    // Counter widths are $clog2(max+1), floored at 1 bit for degenerate ranges.
    localparam int unsigned CF_W = (CF > 1)      ? $clog2(CF)      : 1;
    localparam int unsigned K_W  = (K > 1)       ? $clog2(K)       : 1;
    localparam int unsigned O_W  = (OFM_DIM > 1) ? $clog2(OFM_DIM) : 1;

    localparam logic [CF_W-1:0] CF_MAX  = CF_W'(CF - 1);
    localparam logic [K_W-1:0]  K_MAX   = K_W'(K - 1);
    localparam logic [O_W-1:0]  O_MAX   = O_W'(OFM_DIM - 1);
    // First kernel row/column not already covered by the previous window.
    localparam logic [K_W-1:0]  K_FRESH = K_W'(K - STRIDE);

    logic [CF_W-1:0] r_cf;
    logic [K_W-1:0]  r_kw;
    logic [K_W-1:0]  r_kh;
    logic [O_W-1:0]  r_ow;
    logic [O_W-1:0]  r_oh;

    logic                      r_out_valid;
    logic [BIT_WIDTH*SIMD-1:0] r_out_data;
    logic                      r_out_last;

    logic w_cf_last;
    logic w_kw_last;
    logic w_kh_last;
    logic w_ow_last;
    logic w_oh_last;
    logic w_frame_last;
    logic w_keep;
    logic w_in_ready;
    logic w_in_fire;

    always_comb begin
        w_cf_last    = (r_cf == CF_MAX);
        w_kw_last    = (r_kw == K_MAX);
        w_kh_last    = (r_kh == K_MAX);
        w_ow_last    = (r_ow == O_MAX);
        w_oh_last    = (r_oh == O_MAX);
        w_frame_last = w_cf_last && w_kw_last && w_kh_last && w_ow_last && w_oh_last;

        // A beat is new when its row is not shared with the window above and
        // its column is not shared with the window to the left.
        w_keep = ((r_oh == '0) || (r_kh >= K_FRESH)) &&
                 ((r_ow == '0) || (r_kw >= K_FRESH));

        // Dropped beats never need the output register, so they are always taken.
        w_in_ready = !ap_rst && (!w_keep || !r_out_valid || out_V_V_TREADY);
        w_in_fire  = in0_V_V_TVALID && w_in_ready;
    end

    // Nested counters; a full-frame wrap falls out of every level wrapping at once.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_cf <= '0;
            r_kw <= '0;
            r_kh <= '0;
            r_ow <= '0;
            r_oh <= '0;
        end else if (w_in_fire) begin
            r_cf <= w_cf_last ? '0 : r_cf + 1'b1;
            if (w_cf_last) begin
                r_kw <= w_kw_last ? '0 : r_kw + 1'b1;
            end
            if (w_cf_last && w_kw_last) begin
                r_kh <= w_kh_last ? '0 : r_kh + 1'b1;
            end
            if (w_cf_last && w_kw_last && w_kh_last) begin
                r_ow <= w_ow_last ? '0 : r_ow + 1'b1;
            end
            if (w_cf_last && w_kw_last && w_kh_last && w_ow_last) begin
                r_oh <= w_oh_last ? '0 : r_oh + 1'b1;
            end
        end
    end

    // Single output stage: reload wins over drain so back-to-back kept beats
    // flow at one per cycle.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
        end else if (w_in_fire && w_keep) begin
            r_out_valid <= 1'b1;
            r_out_data  <= in0_V_V_TDATA;
            r_out_last  <= w_frame_last;
        end else if (out_V_V_TREADY) begin
            r_out_valid <= 1'b0;
        end
    end

    always_comb begin
        in0_V_V_TREADY = w_in_ready;
        out_V_V_TVALID = r_out_valid;
        out_V_V_TDATA  = r_out_data;
    end

`ifdef SWG_DEDUP_TLAST_EN
    always_comb begin
        out_V_V_TLAST = r_out_last;
    end
`else
    // Last-beat flag has no consumer in this build.
    logic w_unused_last;
    always_comb begin
        w_unused_last = r_out_last;
    end
`endif

endmodule
